spimemio_icache: RTL and testbench

//  Direct-mapped read-only line cache between the CPU flash-window bus and spimemio.

---
 rtl/spimemio_icache.sv | 141 ++++++++++++++
 tb/tb_spimemio_icache.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spimemio_icache.sv
// Direct-mapped read-only line cache between the CPU flash window and spimemio.
// Optional hit/miss statistics counters are enabled by defining SPIMEMIO_ICACHE_STATS_EN.
module spimemio_icache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [23:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        flash_valid,
  input  logic        flash_ready,
  output logic [23:0] flash_addr,
  input  logic [31:0] flash_rdata
`ifdef SPIMEMIO_ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int TW = 22 - IB - OB;
  localparam int AW = IB + OB;
  localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t          state_reg, state_next;
  logic [LINES-1:0] valid_reg;
  logic [TW-1:0]   tag_mem [LINES];
  logic [31:0]     data_mem [LINES*LINE_WORDS];
  logic [OW-1:0]   fill_cnt;
  logic            fill_kill;

  logic [IB-1:0]   idx;
  logic [TW-1:0]   tag_in;
  logic [OW-1:0]   off;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic            hit, lookup_hit, lookup_miss, fill_hs, fill_last;
  logic            unused_addr_bits;

  assign idx    = mem_addr[IB+OB+1:OB+2];
  assign tag_in = mem_addr[23:IB+OB+2];
  assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

  // A single-word line has no offset field; the word index is just the line index.
  generate
    if (OB > 0) begin : g_off
      assign off     = mem_addr[OB+1:2];
      assign rd_addr = {idx, off};
      assign wr_addr = {idx, fill_cnt};
    end else begin : g_nooff
      logic unused_fill_cnt;
      assign off     = '0;
      assign rd_addr = idx;
      assign wr_addr = idx;
      assign unused_fill_cnt = &{1'b0, fill_cnt, off};
    end
  endgenerate

  // A flush in the lookup cycle forces a miss so stale lines are never served.
  assign hit         = valid_reg[idx] && (tag_mem[idx] == tag_in) && !flush;
  assign lookup_hit  = (state_reg == IDLE) && mem_valid && hit;
  assign lookup_miss = (state_reg == IDLE) && mem_valid && !hit;
  assign fill_hs     = (state_reg == FILL) && flash_valid && flash_ready;
  assign fill_last   = fill_hs && (fill_cnt == LAST_WORD);

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_valid) state_next = hit ? RESP : FILL;
      FILL:    if (fill_last) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_reg   <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      flash_valid <= 1'b0;
      flash_addr  <= '0;
      fill_cnt    <= '0;
      fill_kill   <= 1'b0;
    end else begin
      mem_ready <= (state_next == RESP);
      if (lookup_hit) mem_rdata <= data_mem[rd_addr];
      if (lookup_miss) begin
        flash_addr  <= {mem_addr[23:OB+2], {(OB+2){1'b0}}};
        fill_cnt    <= '0;
        flash_valid <= 1'b1;
        fill_kill   <= 1'b0;
      end
      if (fill_hs) begin
        if (fill_cnt == off) mem_rdata <= flash_rdata;
        if (fill_last) begin
          flash_valid <= 1'b0;
        end else begin
          fill_cnt   <= fill_cnt + OW'(1);
          flash_addr <= flash_addr + 24'd4;
        end
      end
      // The line being filled still completes, but must not become valid after a flush.
      if ((state_reg == FILL) && flush) fill_kill <= 1'b1;
      if (flush)          valid_reg      <= '0;
      else if (fill_last) valid_reg[idx] <= !fill_kill;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_hs)   data_mem[wr_addr] <= flash_rdata;
    if (fill_last) tag_mem[idx]      <= tag_in;
  end

`ifdef SPIMEMIO_ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
      if (lookup_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spimemio_icache.sv
// Directed bench for spimemio_icache with a latency-2 flash responder and handshake log.
// Statistics checks are compiled in when SPIMEMIO_ICACHE_STATS_EN is defined.
module tb_spimemio_icache;
  localparam int LINES = 16;
  localparam int LINE_WORDS = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [23:0] mem_addr = '0;
  logic [31:0] mem_rdata;
  logic        flush = 1'b0;
  logic        flash_valid;
  logic        flash_ready;
  logic [23:0] flash_addr;
  logic [31:0] flash_rdata;
`ifdef SPIMEMIO_ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int wait_cnt = 0;
  logic [23:0] hs_log[$];

  spimemio_icache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .flush(flush),
    .flash_valid(flash_valid), .flash_ready(flash_ready), .flash_addr(flash_addr), .flash_rdata(flash_rdata)
`ifdef SPIMEMIO_ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fword(input logic [23:0] a);
    return {a, 8'h5A} ^ 32'h1357_9BDF;
  endfunction

  // Flash responder: ready after two wait cycles, data is a fixed function of address.
  assign flash_ready = flash_valid && (wait_cnt >= 2);
  assign flash_rdata = flash_valid ? fword(flash_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flash_valid && flash_ready) begin
      hs_log.push_back(flash_addr);
      last_hs_cyc <= cyc;
      wait_cnt <= 0;
    end else if (flash_valid) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [23:0] addr, input bit exp_hit, input int flush_at, input string name);
    int start_cyc, hs0, n, rdy_cyc;
    bit got, flushed;
    logic [23:0] base;
    hs0 = hs_log.size();
    start_cyc = cyc;
    rdy_cyc = 0;
    got = 0;
    flushed = 0;
    base = addr & ~24'(LINE_WORDS*4 - 1);
    mem_addr = addr;
    mem_valid = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      if (mem_ready) begin
        got = 1;
        rdy_cyc = cyc;
      end else if (!flushed && flush_at >= 0 && (hs_log.size() - hs0) == flush_at) begin
        flush = 1'b1;
        flushed = 1;
      end
    end
    mem_valid = 1'b0;
    flush = 1'b0;
    n = hs_log.size() - hs0;
    $display("read %s addr=%h data=%h flash_words=%0d ready_cyc=%0d", name, addr, mem_rdata, n, rdy_cyc);
    chk({name, "_ready"}, 32'(got), 32'd1);
    chk({name, "_data"}, mem_rdata, fword(addr & ~24'd3));
    chk({name, "_nwords"}, 32'(n), exp_hit ? 32'd0 : 32'(LINE_WORDS));
    if (exp_hit) begin
      chk({name, "_lat"}, 32'(rdy_cyc), 32'(start_cyc + 1));
    end else begin
      chk({name, "_lat"}, 32'(rdy_cyc), 32'(last_hs_cyc + 1));
      for (int i = 0; i < n && i < LINE_WORDS; i++)
        chk({name, "_faddr"}, 32'(hs_log[hs0 + i]), 32'(base + 24'(4*i)));
    end
    @(posedge clk); @(negedge clk);
    chk({name, "_pulse"}, 32'(mem_ready), 32'd0);
    chk({name, "_fvidle"}, 32'(flash_valid), 32'd0);
  endtask

  initial begin
    int hs0;
    bit reached, saw_ready;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_fvalid", 32'(flash_valid), 32'd0);
    chk("rst_faddr", 32'(flash_addr), 32'd0);
`ifdef SPIMEMIO_ICACHE_STATS_EN
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
`endif
    resetn = 1'b1;
    @(negedge clk);

    do_read(24'h000104, 1'b0, -1, "cold104");
    do_read(24'h00010C, 1'b1, -1, "hit10C");
    do_read(24'h000204, 1'b0, -1, "conflict204");
    do_read(24'h000104, 1'b0, -1, "reread104");
    do_read(24'h000040, 1'b0, 1, "flushfill040");
    do_read(24'h000040, 1'b0, -1, "refill040");
    do_read(24'h000044, 1'b1, -1, "hit044");

    // Reset asserted while the third word of a fill is outstanding.
    hs0 = hs_log.size();
    reached = 0;
    saw_ready = 0;
    mem_addr = 24'h000080;
    mem_valid = 1'b1;
    for (int k = 0; k < 100 && !reached; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_ready) saw_ready = 1;
      if ((hs_log.size() - hs0) == 2) reached = 1;
    end
    chk("rstfill_reach", 32'(reached), 32'd1);
    resetn = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstfill_fvalid", 32'(flash_valid), 32'd0);
    if (mem_ready) saw_ready = 1;
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_ready) saw_ready = 1;
    end
    $display("reset mid-fill words=%0d flash_valid=%b", hs_log.size() - hs0, flash_valid);
    chk("rstfill_noready", 32'(saw_ready), 32'd0);
    chk("rstfill_fvidle", 32'(flash_valid), 32'd0);

    do_read(24'h000104, 1'b0, -1, "postrst104");
    do_read(24'h000088, 1'b0, -1, "miss088");
    do_read(24'h00008C, 1'b1, -1, "hit08C");
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    $display("flush in idle");
    do_read(24'h000088, 1'b0, -1, "flushed088");

`ifdef SPIMEMIO_ICACHE_STATS_EN
    resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_read(24'h000300, 1'b0, -1, "st_miss300");
    do_read(24'h000304, 1'b1, -1, "st_hit304");
    do_read(24'h000308, 1'b1, -1, "st_hit308");
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    do_read(24'h000300, 1'b0, -1, "st_miss300b");
    $display("stats hits=%0d misses=%0d", hit_count, miss_count);
    chk("stats_hits", hit_count, 32'd2);
    chk("stats_misses", miss_count, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
